// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from an async FIFO and presents them as a valid/ready stream.
// Optional macro FIFO_RD_STREAM_CNT_EN adds a 16-bit transfer counter output (word_cnt).
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 4,
   parameter int BUF_PTR    = 2
) (
   input  logic                  clkb,
   input  logic                  rstb,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
`ifdef FIFO_RD_STREAM_CNT_EN
   output logic [15:0]           word_cnt,
`endif
   output logic [BUF_PTR:0]      buf_level
);

   logic [DATA_WIDTH-1:0] buf_mem_r [BUF_DEPTH];
   logic [BUF_PTR:0]      occ_r;
   logic                  pend_r;
   logic [BUF_PTR-1:0]    wr_idx_r;
   logic [BUF_PTR-1:0]    rd_idx_r;
   logic                  pop_s;
   logic [BUF_PTR+1:0]    inflight_s;

   // Words held plus the word arriving this cycle; the read about to issue must still fit.
   assign inflight_s = {1'b0, occ_r} + {{(BUF_PTR+1){1'b0}}, pend_r};
   assign fifo_rd_en = !rstb && !fifo_empty && (inflight_s < (BUF_PTR+2)'(BUF_DEPTH));

   assign m_valid   = (occ_r != {(BUF_PTR+1){1'b0}});
   assign pop_s     = m_valid && m_ready;
   assign m_data    = buf_mem_r[rd_idx_r];
   assign buf_level = occ_r;

   // Skid buffer state: capture the word read last cycle, retire on transfer.
   always_ff @(posedge clkb or posedge rstb) begin
      if (rstb) begin
         occ_r    <= {(BUF_PTR+1){1'b0}};
         pend_r   <= 1'b0;
         wr_idx_r <= {BUF_PTR{1'b0}};
         rd_idx_r <= {BUF_PTR{1'b0}};
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         pend_r <= fifo_rd_en;
         if (pend_r) begin
            buf_mem_r[wr_idx_r] <= fifo_data;
            wr_idx_r            <= wr_idx_r + BUF_PTR'(1);
         end else begin
            wr_idx_r <= wr_idx_r;
         end
         if (pop_s) begin
            rd_idx_r <= rd_idx_r + BUF_PTR'(1);
         end else begin
            rd_idx_r <= rd_idx_r;
         end
         occ_r <= occ_r + {{BUF_PTR{1'b0}}, pend_r} - {{BUF_PTR{1'b0}}, pop_s};
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] word_cnt_r;

   // Free-running count of stream transfers, wrapping at 16 bits.
   always_ff @(posedge clkb or posedge rstb) begin
      if (rstb) begin
         word_cnt_r <= 16'h0000;
      end else if (pop_s) begin
         word_cnt_r <= word_cnt_r + 16'h0001;
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a 1-cycle-latency FIFO read model.
// Define FIFO_RD_STREAM_CNT_EN to also exercise the word_cnt counter.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [2:0] buf_level;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] word_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // FIFO model: words pushed by the stimulus, popped with one cycle of read latency
   logic [7:0] mem [0:255];
   int         wr_ptr   = 0;
   int         rd_ptr;
   logic       inf_mode = 1'b0;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr) && !inf_mode;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= wr_ptr;
         fifo_data <= 8'h00;
      end else if (fifo_rd_en) begin
         fifo_data <= inf_mode ? 8'hA5 : mem[rd_ptr[7:0]];
         if (!inf_mode) rd_ptr <= rd_ptr + 1;
      end
   end

   fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(4), .BUF_PTR(2)) dut (
      .clkb       (clk),
      .rstb       (rst),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
`ifdef FIFO_RD_STREAM_CNT_EN
      .word_cnt   (word_cnt),
`endif
      .buf_level  (buf_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[7:0]] = d;
      wr_ptr++;
   endtask

   initial begin
      int base;
      #2 rst = 1'b1;

      // 1: reset and idle with an empty FIFO
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("rst_rd_en", fifo_rd_en, 1'b0);
         chk("rst_valid", m_valid, 1'b0);
         chk("rst_level", buf_level, 3'd0);
         chk("rst_data", m_data, 8'h00);
      end
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("idle_rd_en", fifo_rd_en, 1'b0);
         chk("idle_valid", m_valid, 1'b0);
         chk("idle_level", buf_level, 3'd0);
         cyc();
      end

      // 2: three words, downstream always ready
      m_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33);
      smp();
      chk("t2_rd_en0", fifo_rd_en, 1'b1);
      chk("t2_valid0", m_valid, 1'b0);
      cyc(); smp();
      chk("t2_valid1", m_valid, 1'b0);
      cyc(); smp();
      chk("t2_valid2", m_valid, 1'b1);
      chk("t2_data2", m_data, 8'h11);
      cyc(); smp();
      chk("t2_valid3", m_valid, 1'b1);
      chk("t2_data3", m_data, 8'h22);
      cyc(); smp();
      chk("t2_valid4", m_valid, 1'b1);
      chk("t2_data4", m_data, 8'h33);
      cyc(); smp();
      chk("t2_valid5", m_valid, 1'b0);
      chk("t2_level5", buf_level, 3'd0);
      cyc();

      // 3: eight words, downstream stalled
      m_ready = 1'b0;
      base = rd_ptr;
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 8; i++) cyc();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t3_level", buf_level, 3'd4);
         chk("t3_rd_en", fifo_rd_en, 1'b0);
         chk("t3_valid", m_valid, 1'b1);
         chk("t3_data", m_data, 8'hA0);
         chk("t3_reads", rd_ptr - base, 4);
         cyc();
      end

      // 4: release the stall, all eight words back to back
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         smp();
         chk("t4_valid", m_valid, 1'b1);
         chk("t4_data", m_data, 8'hA0 + 8'(i));
         if (i == 5) begin
            chk("t4_empty", fifo_empty, 1'b1);
            chk("t4_rd_en_drop", fifo_rd_en, 1'b0);
         end
         cyc();
      end
      smp();
      chk("t4_valid_end", m_valid, 1'b0);
      chk("t4_level_end", buf_level, 3'd0);
      cyc();

      // 5: reset with three buffered words and one in flight
      m_ready = 1'b0;
      push(8'h51); push(8'h52); push(8'h53); push(8'h54);
      for (int i = 0; i < 4; i++) cyc();
      smp();
      chk("t5_level_pre", buf_level, 3'd3);
      #1 rst = 1'b1;
      #1;
      chk("t5_valid_rst", m_valid, 1'b0);
      chk("t5_level_rst", buf_level, 3'd0);
      chk("t5_rd_en_rst", fifo_rd_en, 1'b0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t5_no_stale", m_valid, 1'b0);
         chk("t5_rd_en_idle", fifo_rd_en, 1'b0);
         cyc();
      end
      m_ready = 1'b1;
      push(8'h77);
      cyc(); cyc(); smp();
      chk("t5_new_valid", m_valid, 1'b1);
      chk("t5_new_data", m_data, 8'h77);
      cyc(); smp();
      chk("t5_new_done", m_valid, 1'b0);
      cyc();

`ifdef FIFO_RD_STREAM_CNT_EN
      // 6: transfer counter, then wrap from 0xFFFF
      rst = 1'b1;
      #1;
      chk("t6_cnt_rst", word_cnt, 16'h0000);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc();
         m_ready = ~m_ready;
      end
      smp();
      chk("t6_cnt5", word_cnt, 16'd5);
      chk("t6_valid", m_valid, 1'b0);
      cyc();
      inf_mode = 1'b1;
      m_ready  = 1'b1;
      for (int g = 0; g < 70000 && word_cnt !== 16'hFFFF; g++) cyc();
      smp();
      chk("t6_cnt_ffff", word_cnt, 16'hFFFF);
      chk("t6_valid_ffff", m_valid, 1'b1);
      cyc();
      m_ready  = 1'b0;
      inf_mode = 1'b0;
      smp();
      chk("t6_cnt_wrap", word_cnt, 16'h0000);
      cyc(); smp();
      chk("t6_cnt_hold", word_cnt, 16'h0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
